// File: rtl/hazard_sequencer_pkg.sv
// hazard_sequencer_pkg
//   Shared definitions for the hazard sequencer slice: sequencer state
//   encoding, execute-stage PC-select codes, default widths, and the
//   redirect decode helper.
package hazard_sequencer_pkg;

  localparam int REG_ADDR_W_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_t;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_BR   = 2'b01;
  localparam logic [1:0] PCSEL_JAL  = 2'b10;
  localparam logic [1:0] PCSEL_HOLD = 2'b11;

  // Only a taken branch or a JAL changes the fetch stream; sequential and
  // hold selects leave the instructions behind the execute stage valid.
  function automatic logic is_redirect(input logic ex_valid, input logic [1:0] pc_sel);
    return ex_valid && ((pc_sel == PCSEL_BR) || (pc_sel == PCSEL_JAL));
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// hazard_sequencer_if
//   Bundle between the pipeline datapath (master) and the hazard sequencer
//   (slave).
//   master drives : dec_valid, dec_s1Addr, dec_s2Addr, dec_s1Used,
//                   dec_s2Used, dec_dAddr, dec_wrtEn, ex_valid, ex_pcSel,
//                   cntClr
//   slave drives  : bubble, stallFetch, flush, bubbleCount
//
// Handshake: dec_valid qualifies every dec_* field in the same cycle. The
// decode instruction is accepted (leaves decode) in a cycle where
// dec_valid=1 and bubble=0; bubble=1 squashes it, and stallFetch=1 is the
// back-pressure that keeps it in place for re-presentation next cycle.
// ex_valid qualifies ex_pcSel. All slave outputs are valid every cycle.
interface hazard_sequencer_if
  import hazard_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) ();

  logic                  dec_valid;
  logic [REG_ADDR_W-1:0] dec_s1Addr;
  logic [REG_ADDR_W-1:0] dec_s2Addr;
  logic                  dec_s1Used;
  logic                  dec_s2Used;
  logic [REG_ADDR_W-1:0] dec_dAddr;
  logic                  dec_wrtEn;
  logic                  ex_valid;
  logic [1:0]            ex_pcSel;
  logic                  cntClr;
  logic                  bubble;
  logic                  stallFetch;
  logic                  flush;
  logic [CNT_W-1:0]      bubbleCount;

  modport master (
    output dec_valid, dec_s1Addr, dec_s2Addr, dec_s1Used, dec_s2Used,
           dec_dAddr, dec_wrtEn, ex_valid, ex_pcSel, cntClr,
    input  bubble, stallFetch, flush, bubbleCount
  );

  modport slave (
    input  dec_valid, dec_s1Addr, dec_s2Addr, dec_s1Used, dec_s2Used,
           dec_dAddr, dec_wrtEn, ex_valid, ex_pcSel, cntClr,
    output bubble, stallFetch, flush, bubbleCount
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Three-entry {valid, addr} shift register tracking pending register
//   writes in EX, MEM and WB, plus two parallel lookups against it.
//   clk, reset_n            : clock, async active-low reset
//   push_valid, push_addr   : entry loaded into EX each clock
//   lookup1_addr/2_addr     : decode source addresses to compare
//   match1, match2          : lookup hits any valid entry
module hazard_scoreboard
  import hazard_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_valid,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [REG_ADDR_W-1:0] lookup1_addr,
  input  logic [REG_ADDR_W-1:0] lookup2_addr,
  output logic                  match1,
  output logic                  match2
);

  logic                  ex_v, mem_v, wb_v;
  logic [REG_ADDR_W-1:0] ex_a, mem_a, wb_a;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_v  <= 1'b0;
      ex_a  <= '0;
      mem_v <= 1'b0;
      mem_a <= '0;
      wb_v  <= 1'b0;
      wb_a  <= '0;
    end else begin
      // A squashed or non-writing slot enters as {0,0} so stale addresses
      // never linger in an invalid entry.
      ex_v  <= push_valid;
      ex_a  <= push_valid ? push_addr : '0;
      mem_v <= ex_v;
      mem_a <= ex_a;
      wb_v  <= mem_v;
      wb_a  <= mem_a;
    end
  end

  // No register is exempt: address 0 is tracked like any other.
  always_comb begin
    match1 = (ex_v  && (ex_a  == lookup1_addr)) ||
             (mem_v && (mem_a == lookup1_addr)) ||
             (wb_v  && (wb_a  == lookup1_addr));
    match2 = (ex_v  && (ex_a  == lookup2_addr)) ||
             (mem_v && (mem_a == lookup2_addr)) ||
             (wb_v  && (wb_a  == lookup2_addr));
  end

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Decode-stage interlock and control-flow flush sequencer.
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   bus       : hazard_sequencer_if slave (decode/execute info in,
//               bubble/stallFetch/flush/bubbleCount out)
//   dbg_state : current sequencer state
//   Outputs are combinational from state, scoreboard and inputs; a
//   redirect from execute always outranks a data hazard in decode.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hazard_sequencer_if.slave    bus,
  output seq_state_t           dbg_state
);

  seq_state_t       state, state_nxt;
  logic             s1_match, s2_match;
  logic             hazard, redirect, push_valid;
  logic             bubble_c, stall_c, flush_c;
  logic [CNT_W-1:0] cnt_q;

  // Only an instruction that actually leaves decode reserves its target.
  assign push_valid = bus.dec_valid & bus.dec_wrtEn & ~bubble_c;

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_valid   (push_valid),
    .push_addr    (bus.dec_dAddr),
    .lookup1_addr (bus.dec_s1Addr),
    .lookup2_addr (bus.dec_s2Addr),
    .match1       (s1_match),
    .match2       (s2_match)
  );

  assign hazard   = (bus.dec_s1Used & s1_match) | (bus.dec_s2Used & s2_match);
  assign redirect = is_redirect(bus.ex_valid, bus.ex_pcSel);

  always_comb begin
    state_nxt = state;
    bubble_c  = 1'b0;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    case (state)
      ST_RUN: begin
        if (redirect) begin
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
          state_nxt = ST_FLUSH;
        end else if (hazard && bus.dec_valid) begin
          bubble_c  = 1'b1;
          stall_c   = 1'b1;
          state_nxt = ST_STALL;
        end
      end
      ST_STALL: begin
        if (redirect) begin
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
          state_nxt = ST_FLUSH;
        end else if (hazard) begin
          bubble_c  = 1'b1;
          stall_c   = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // The slot behind the redirect is wrong-path; squash it and ignore
        // execute, which now holds that same wrong-path instruction.
        bubble_c  = 1'b1;
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
    // Hold the front end quiet while in reset.
    if (!reset_n) begin
      bubble_c = 1'b1;
      stall_c  = 1'b1;
      flush_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (bus.cntClr) begin
      cnt_q <= '0;
    end else if (bubble_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.bubble      = bubble_c;
  assign bus.stallFetch  = stall_c;
  assign bus.flush       = flush_c;
  assign bus.bubbleCount = cnt_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;
  import hazard_sequencer_pkg::*;

  // Expected entry: {cycle[31:0], state[1:0], bubble, stallFetch, flush, count[15:0]}
  localparam int W = 53;

  // ---------------- clock / reset ----------------
  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  seq_state_t dbg_state;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hazard_sequencer_if #(.REG_ADDR_W(4), .CNT_W(16)) bus ();

  hazard_sequencer #(
    .REG_ADDR_W (4),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic         quiet    = 1'b0;
  logic [15:0]  exp_cnt  = 16'h0;

  // ---------------- driver ----------------
  // One call = one clock cycle: apply inputs just after the rising edge,
  // queue the expected outputs for this cycle, advance to the next edge,
  // then advance the expected bubble count.
  task automatic step(input int rst, input int dv, input int s1, input int s1u,
                      input int s2, input int s2u, input int d, input int we,
                      input int ev, input int pc, input int clr,
                      input seq_state_t est, input int eb, input int es, input int ef);
    reset_n        = ~1'(rst);
    bus.dec_valid  = 1'(dv);
    bus.dec_s1Addr = 4'(s1);
    bus.dec_s1Used = 1'(s1u);
    bus.dec_s2Addr = 4'(s2);
    bus.dec_s2Used = 1'(s2u);
    bus.dec_dAddr  = 4'(d);
    bus.dec_wrtEn  = 1'(we);
    bus.ex_valid   = 1'(ev);
    bus.ex_pcSel   = 2'(pc);
    bus.cntClr     = 1'(clr);
    if (rst != 0) exp_cnt = 16'h0;
    if (!quiet) exp_q.push_back({cyc, est, 1'(eb), 1'(es), 1'(ef), exp_cnt});
    @(posedge clk);
    #1;
    if (rst == 0) begin
      if (clr != 0) exp_cnt = 16'h0;
      else if (eb != 0 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
    end
  endtask

  task automatic idle(input seq_state_t est, input int eb, input int es, input int ef);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, est, eb, es, ef);
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  logic [20:0]  mon_act;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][W-1:21] <= cyc) begin
      mon_e   = exp_q.pop_front();
      mon_act = {dbg_state, bus.bubble, bus.stallFetch, bus.flush, bus.bubbleCount};
      n_checks++;
      if (mon_e[W-1:21] != cyc) begin
        n_fail++;
        $display("FAIL stale_entry: queued for cycle %0d, checked at cycle %0d", mon_e[W-1:21], cyc);
      end else if (mon_act != mon_e[20:0]) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got state=%0d bubble=%b stallFetch=%b flush=%b bubbleCount=%h, expected state=%0d bubble=%b stallFetch=%b flush=%b bubbleCount=%h",
                 cyc, mon_act[20:19], mon_act[18], mon_act[17], mon_act[16], mon_act[15:0],
                 mon_e[20:19], mon_e[18], mon_e[17], mon_e[16], mon_e[15:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_500_000;
    n_fail++;
    $display("FAIL timeout: stimulus did not complete, %0d entries left", exp_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  // step(rst, dv, s1, s1u, s2, s2u, d, we, ev, pc, clr, state, bubble, stallFetch, flush)
  initial begin
    bus.dec_valid  = 1'b0;
    bus.dec_s1Addr = 4'h0;
    bus.dec_s1Used = 1'b0;
    bus.dec_s2Addr = 4'h0;
    bus.dec_s2Used = 1'b0;
    bus.dec_dAddr  = 4'h0;
    bus.dec_wrtEn  = 1'b0;
    bus.ex_valid   = 1'b0;
    bus.ex_pcSel   = 2'b00;
    bus.cntClr     = 1'b0;
    @(posedge clk);
    #1;

    // Reset: bubble and stallFetch held high, flush low, even with a redirect present
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_RUN, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, ST_RUN, 1, 1, 0);
    idle(ST_RUN, 0, 0, 0);

    // Write R3 then read it via s1: three bubble/stall cycles, issue on the 4th, count 3
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, ST_RUN,   0, 0, 0);
    step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, ST_RUN,   1, 1, 0);
    step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, ST_STALL, 1, 1, 0);
    step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, ST_STALL, 1, 1, 0);
    step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, ST_STALL, 0, 0, 0);
    idle(ST_RUN, 0, 0, 0);

    // Write R2, gap, read via s2: hit in MEM, two bubbles
    step(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, ST_RUN,   0, 0, 0);
    idle(ST_RUN, 0, 0, 0);
    step(0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, ST_RUN,   1, 1, 0);
    step(0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, ST_STALL, 1, 1, 0);
    step(0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, ST_STALL, 0, 0, 0);
    idle(ST_RUN, 0, 0, 0);

    // Taken branch: flush one cycle, bubble two cycles
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, ST_RUN,   1, 0, 1);
    idle(ST_FLUSH, 1, 0, 0);
    idle(ST_RUN, 0, 0, 0);

    // JAL, with a redirect still presented in FLUSH (ignored)
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, ST_RUN,   1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, ST_FLUSH, 1, 0, 0);
    idle(ST_RUN, 0, 0, 0);

    // Redirect in the same cycle as a pending R5 hazard: flush wins
    step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, ST_RUN,   0, 0, 0);
    step(0, 1, 0, 0, 5, 1, 0, 0, 1, 1, 0, ST_RUN,   1, 0, 1);
    idle(ST_FLUSH, 1, 0, 0);
    idle(ST_RUN, 0, 0, 0);
    idle(ST_RUN, 0, 0, 0);

    // Redirect arriving while already stalled on R7
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, ST_RUN,   0, 0, 0);
    step(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, ST_RUN,   1, 1, 0);
    step(0, 1, 7, 1, 0, 0, 0, 0, 1, 2, 0, ST_STALL, 1, 0, 1);
    idle(ST_FLUSH, 1, 0, 0);
    idle(ST_RUN, 0, 0, 0);

    // Unused sources, no dec_valid, non-redirect pcSel values
    step(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, ST_RUN, 0, 0, 0);
    step(0, 1, 9, 0, 9, 0, 0, 0, 0, 0, 0, ST_RUN, 0, 0, 0);
    step(0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, ST_RUN, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, ST_RUN, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ST_RUN, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ST_RUN, 0, 0, 0);

    // dec_wrtEn=0 reserves nothing
    step(0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, ST_RUN, 0, 0, 0);
    step(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, ST_RUN, 0, 0, 0);

    // R0 is tracked like any other register
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, ST_RUN,   0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, ST_RUN,   1, 1, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, ST_STALL, 1, 1, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, ST_STALL, 1, 1, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, ST_STALL, 0, 0, 0);
    idle(ST_RUN, 0, 0, 0);

    // Reset mid-STALL: immediate bubble, then R6 read issues cleanly
    step(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, ST_RUN, 0, 0, 0);
    step(0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, ST_RUN, 1, 1, 0);
    step(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, ST_RUN, 1, 1, 0);
    step(0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, ST_RUN, 0, 0, 0);
    idle(ST_RUN, 0, 0, 0);

    // Reset mid-FLUSH abandons the sequence
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, ST_RUN, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_RUN, 1, 1, 0);
    idle(ST_RUN, 0, 0, 0);

    // Saturation: clear, then a continuous redirect stream bubbles every cycle
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ST_RUN, 0, 0, 0);
    quiet = 1'b1;
    for (int k = 0; k < 65537; k++) begin
      if (k >= 65533) quiet = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,
           (k % 2 == 0) ? ST_RUN : ST_FLUSH, 1, 0, (k % 2 == 0) ? 1 : 0);
    end
    quiet = 1'b0;
    // cntClr on a bubble cycle wins over the increment
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, ST_FLUSH, 1, 0, 0);
    idle(ST_RUN, 0, 0, 0);

    // Drain and report
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
